// File: rtl/vga_fetch_arbiter.sv
// Shares one single-port pixel RAM between VGA line fetch and a host port.
// Fetch copies one row into the line buffer; the host gets a slot at each burst boundary.
module vga_fetch_arbiter #(
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned FETCH_BURST = 32,
    parameter int unsigned ADDR_W      = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              line_req_i,
    input  logic [10:0]       line_y_i,
    output logic              fetch_busy_o,
    output logic              overrun_o,
    output logic              lb_we_o,
    output logic [9:0]        lb_addr_o,
    output logic [7:0]        lb_data_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [7:0]        host_wdata_i,
    output logic              host_ack_o,
    output logic [7:0]        host_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    localparam int unsigned BW = $clog2(FETCH_BURST + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StHost, StDrain} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [9:0]        x_q;
    logic [BW-1:0]     burst_q;
    logic              fetch_busy_q;
    logic              overrun_q;
    logic              lb_we_q;
    logic [9:0]        lb_addr_q;
    logic              host_rd_q;
    logic              host_ack_q;
    logic              host_rd_ack_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;

    logic              line_ok;
    logic              host_pend;
    logic [31:0]       prod;
    logic [ADDR_W-1:0] start_addr;
    logic [9:0]        x_nxt;

    always_comb begin
        line_ok    = line_req_i && (32'(line_y_i) < V_ACT);
        host_pend  = host_req_i && !host_ack_q;
        prod       = 32'(line_y_i) * H_ACT;
        start_addr = prod[ADDR_W-1:0];
        x_nxt      = x_q + 10'd1;
    end

    // In StFetch, x_q is the index of the read on the bus this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            base_q        <= '0;
            x_q           <= '0;
            burst_q       <= '0;
            fetch_busy_q  <= 1'b0;
            overrun_q     <= 1'b0;
            lb_we_q       <= 1'b0;
            lb_addr_q     <= '0;
            host_rd_q     <= 1'b0;
            host_ack_q    <= 1'b0;
            host_rd_ack_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            host_ack_q    <= (state_q == StHost);
            host_rd_ack_q <= (state_q == StHost) && host_rd_q;
            lb_we_q       <= (state_q == StFetch);
            if (state_q == StFetch) lb_addr_q <= x_q;
            if (line_ok && fetch_busy_q) overrun_q <= 1'b1;
            mem_rd_q <= 1'b0;
            mem_we_q <= 1'b0;

            unique case (state_q)
                StIdle, StHost: begin
                    if (state_q == StHost && fetch_busy_q) begin
                        state_q    <= StFetch;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= base_q + ADDR_W'(x_q);
                        burst_q    <= BW'(1);
                    end else if (line_ok) begin
                        state_q      <= StFetch;
                        fetch_busy_q <= 1'b1;
                        base_q       <= start_addr;
                        mem_addr_q   <= start_addr;
                        mem_rd_q     <= 1'b1;
                        x_q          <= '0;
                        burst_q      <= BW'(1);
                    end else if (state_q == StIdle && host_pend) begin
                        state_q    <= StHost;
                        mem_addr_q <= host_addr_i;
                        mem_we_q   <= host_we_i;
                        mem_rd_q   <= !host_we_i;
                        host_rd_q  <= !host_we_i;
                        if (host_we_i) mem_wdata_q <= host_wdata_i;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StFetch: begin
                    if (x_q == 10'(H_ACT - 1)) begin
                        state_q <= StDrain;
                    end else if (burst_q == BW'(FETCH_BURST) && host_pend) begin
                        state_q    <= StHost;
                        x_q        <= x_nxt;
                        burst_q    <= '0;
                        mem_addr_q <= host_addr_i;
                        mem_we_q   <= host_we_i;
                        mem_rd_q   <= !host_we_i;
                        host_rd_q  <= !host_we_i;
                        if (host_we_i) mem_wdata_q <= host_wdata_i;
                    end else begin
                        x_q        <= x_nxt;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= base_q + ADDR_W'(x_nxt);
                        burst_q    <= (burst_q == BW'(FETCH_BURST)) ? BW'(1) : burst_q + BW'(1);
                    end
                end
                StDrain: begin
                    state_q      <= StIdle;
                    fetch_busy_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read data arrives combinationally one cycle after the strobe.
    assign lb_data_o    = lb_we_q ? mem_rdata_i : 8'd0;
    assign host_rdata_o = host_rd_ack_q ? mem_rdata_i : 8'd0;
    assign fetch_busy_o = fetch_busy_q;
    assign overrun_o    = overrun_q;
    assign lb_we_o      = lb_we_q;
    assign lb_addr_o    = lb_addr_q;
    assign host_ack_o   = host_ack_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_rd_o     = mem_rd_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Scoreboard bench for vga_fetch_arbiter: line-buffer and host results are queued at
// stimulus time and compared when the DUT emits them.
module tb_vga_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_req = 1'b0;
    logic [10:0] line_y = '0;
    logic        fetch_busy, overrun, lb_we, host_ack, mem_rd, mem_we;
    logic [9:0]  lb_addr;
    logic [7:0]  lb_data, host_rdata, mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [18:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [18:0] mem_addr;
    logic [58:0] all_out;

    int checks = 0;
    int failures = 0;

    typedef struct {logic [9:0] a; logic [7:0] d;} lb_exp_t;
    typedef struct {logic rd; logic [7:0] d;} host_exp_t;
    lb_exp_t   lbq[$];
    host_exp_t hq[$];

    int lb_cnt = 0, rd_cnt = 0, we_cnt = 0, ack_cnt = 0, busy_cnt = 0, ack_lb = 0;

    vga_fetch_arbiter dut (
        .clk_i(clk), .rst_i(rst), .line_req_i(line_req), .line_y_i(line_y),
        .fetch_busy_o(fetch_busy), .overrun_o(overrun), .lb_we_o(lb_we),
        .lb_addr_o(lb_addr), .lb_data_o(lb_data), .host_req_i(host_req),
        .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_ack_o(host_ack), .host_rdata_o(host_rdata), .mem_addr_o(mem_addr),
        .mem_rd_o(mem_rd), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    assign all_out = {fetch_busy, overrun, lb_we, lb_addr, lb_data, host_ack, host_rdata,
                      mem_addr, mem_rd, mem_we, mem_wdata};

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [18:0] a);
        return a[7:0] ^ {a[14:8], 1'b0} ^ {5'b0, a[18:16]};
    endfunction

    // RAM model: unwritten locations return a fixed pattern, one written cell is remembered.
    logic        wr_valid = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    always @(posedge clk) begin
        if (mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= (wr_valid && wr_addr == mem_addr) ? wr_data : pix(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_rd === 1'b1 || mem_we === 1'b1) check("rd_we_excl", {mem_rd, mem_we} != 2'b11, 1);
        if (mem_rd === 1'b1) rd_cnt <= rd_cnt + 1;
        if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
        if (fetch_busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (lb_we === 1'b1) begin
            lb_cnt <= lb_cnt + 1;
            if (lbq.size() == 0) begin
                check("lb_unexpected", 1, 0);
            end else begin
                lb_exp_t e;
                e = lbq.pop_front();
                check("lb_addr", lb_addr, e.a);
                check("lb_data", lb_data, e.d);
            end
        end
        if (host_ack === 1'b1) begin
            ack_cnt <= ack_cnt + 1;
            ack_lb  <= lb_cnt;
            if (hq.size() == 0) begin
                check("ack_unexpected", 1, 0);
            end else begin
                host_exp_t h;
                h = hq.pop_front();
                if (h.rd) check("host_rdata", host_rdata, h.d);
            end
        end
    end

    task automatic line_pulse(input int y, input bit push);
        if (push) begin
            for (int x = 0; x < 640; x++) begin
                logic [31:0] p;
                p = y * 640 + x;
                lbq.push_back('{a: 10'(x), d: pix(p[18:0])});
            end
        end
        @(negedge clk);
        line_req = 1'b1;
        line_y   = 11'(y);
        @(negedge clk);
        line_req = 1'b0;
    endtask

    task automatic host_access(input string tag, input bit we, input logic [18:0] a,
                               input logic [7:0] wd, input logic [7:0] exp_rd);
        bit got;
        got = 1'b0;
        hq.push_back('{rd: !we, d: exp_rd});
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        host_req = 1'b0;
        check({tag, "_ack"}, got, 1);
    endtask

    task automatic wait_done(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!fetch_busy && lbq.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, done, 1);
    endtask

    task automatic wait_lb(input int target);
        for (int i = 0; i < 2000; i++) begin
            if (lb_cnt >= target) break;
            @(negedge clk);
        end
    endtask

    int r0, b0, w0, a0, l0;

    initial begin
        @(posedge clk);
        @(negedge clk);
        check("reset_outs", all_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Line 2, no host traffic
        r0 = rd_cnt; b0 = busy_cnt;
        line_pulse(2, 1);
        check("t1_first_addr", {mem_rd, mem_addr}, {1'b1, 19'd1280});
        wait_done("t1_done");
        check("t1_rd_cycles", rd_cnt - r0, 640);
        check("t1_busy_cycles", busy_cnt - b0, 641);
        check("t1_addr_hold", {mem_rd, mem_addr}, {1'b0, 19'd1919});

        // Host write then read in idle
        r0 = rd_cnt; w0 = we_cnt; a0 = ack_cnt;
        host_access("t2_wr", 1'b1, 19'h100, 8'hA5, 8'h00);
        host_access("t2_rd", 1'b0, 19'h100, 8'h00, 8'hA5);
        repeat (2) @(negedge clk);
        check("t2_we_count", we_cnt - w0, 1);
        check("t2_rd_count", rd_cnt - r0, 1);
        check("t2_ack_count", ack_cnt - a0, 2);

        // Invalid line index
        r0 = rd_cnt;
        line_pulse(480, 0);
        repeat (20) @(negedge clk);
        check("t5_no_rd", rd_cnt - r0, 0);
        check("t5_busy", fetch_busy, 0);
        check("t5_overrun", overrun, 0);

        // Host request held from the start of a fetch
        b0 = busy_cnt; a0 = ack_cnt; l0 = lb_cnt;
        fork
            line_pulse(5, 1);
            host_access("t3_rd", 1'b0, 19'h200, 8'h00, pix(19'h200));
        join
        wait_done("t3_done");
        check("t3_ack_count", ack_cnt - a0, 1);
        check("t3_grant_after_burst", ack_lb - l0, 32);
        check("t3_busy_cycles", busy_cnt - b0, 642);

        // Second LINE_REQ mid-fetch
        r0 = rd_cnt; b0 = busy_cnt; l0 = lb_cnt;
        line_pulse(7, 1);
        wait_lb(l0 + 100);
        line_pulse(8, 0);
        check("t4_overrun_set", overrun, 1);
        wait_done("t4_done");
        repeat (5) @(negedge clk);
        check("t4_rd_cycles", rd_cnt - r0, 640);
        check("t4_busy_cycles", busy_cnt - b0, 641);
        check("t4_overrun_sticky", overrun, 1);

        // Reset in the middle of a fetch with a host read pending
        l0 = lb_cnt;
        line_pulse(4, 1);
        wait_lb(l0 + 40);
        host_we = 1'b0; host_addr = 19'h300; host_req = 1'b1;
        wait_lb(l0 + 50);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_outs", all_out, 0);
        lbq.delete();
        hq.delete();
        host_req = 1'b0;
        a0 = ack_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_ack", ack_cnt - a0, 0);
        line_pulse(6, 1);
        check("t6_first_addr", {mem_rd, mem_addr}, {1'b1, 19'd3840});
        wait_done("t6_done");
        check("t6_overrun_clear", overrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
